ssd1331_spi_responder: RTL and testbench
========================================

Name: ssd1331_spi_responder

Overview:
- Synthesizable receive-side model of the SSD1331 OLED controller.
- Oversamples the PMOD SPI lines (CS, MOSI, SCK, D/C, RES) in the system clock domain and deserialises MSB-first bytes.
- Tracks command opcodes and argument counts, and maintains the GDDRAM column/row write pointer inside the window set by 0x15/0x75.
- Emits one pixel-write strobe per data byte. Used as an on-chip loopback checker and as the bench responder for the OLED transmit path.

Parameters:
N, 8, bits per SPI byte
NUM_COL, 96, display columns; column pointer width = clog2(NUM_COL)
NUM_ROW, 64, display rows; row pointer width = clog2(NUM_ROW)

Ports:
i_CLK  in  1  system clock (100 MHz), much faster than SCK
i_RST  in  1  asynchronous active-high reset
i_CS  in  1  SPI chip select, active low, asynchronous to i_CLK
i_MOSI  in  1  serial data, sampled on SCK rising edge
i_SCK  in  1  SPI clock (idle high or low; only rising edges used)
i_DC  in  1  0 = command byte, 1 = GDDRAM data byte
i_RES  in  1  OLED reset, active low
o_BYTE  out  N  last received byte
o_BYTE_DC  out  1  D/C level captured with the byte's last bit
o_BYTE_VALID  out  1  one-cycle strobe per complete byte
o_CMD  out  8  opcode currently collecting arguments
o_ARG_IDX  out  4  index of the argument just received (0-based)
o_ARG_VALID  out  1  one-cycle strobe, byte was a command argument
o_PIX_DATA  out  8  pixel colour (8-bit 332 mode)
o_PIX_COL  out  clog2(NUM_COL)  column written
o_PIX_ROW  out  clog2(NUM_ROW)  row written
o_PIX_VALID  out  1  one-cycle strobe per pixel
o_FRAME_ERR  out  1  sticky: CS rose with a partial byte (1..N-1 bits)

Behaviour:
- Reset (i_RST high, asynchronous): all strobes 0; o_BYTE, o_CMD, o_ARG_IDX, o_PIX_* = 0; o_BYTE_DC = 0; o_FRAME_ERR = 0; bit counter 0; window = col 0..NUM_COL-1, row 0..NUM_ROW-1; pointer = (0,0); parser in IDLE.
- Synchronisation: i_CS, i_MOSI, i_SCK, i_DC, i_RES each pass through 2 flip-flops. A third SCK flop gives the previous value. A rising edge is detected when synced SCK = 1 and previous = 0.
- Shift: on a detected edge while synced CS = 0, shift synced MOSI into the LSB (MSB first) and increment the bit counter.
- Byte latency: on the N-th edge, the counter returns to 0 and the next i_CLK edge registers o_BYTE, o_BYTE_DC and o_BYTE_VALID. o_BYTE_VALID is high exactly 4 i_CLK edges after the pin-level SCK rise is first sampled.
- CS handling: synced CS = 1 clears the bit counter. If the counter was 1..N-1 at that moment, set o_FRAME_ERR. Edges seen while CS is high are ignored.
- i_RES: synced RES = 0 acts as a soft reset of the counter, parser, window and pointer. It does not clear o_FRAME_ERR.
- Parser states: IDLE, ARGS. Every state change and strobe is driven from the o_BYTE_VALID cycle.
- IDLE, command byte:
  - Latch o_CMD and look up the argument count K:
    - 0x15, 0x75 -> 2
    - 0x81, 0x82, 0x83, 0x87, 0x8A, 0x8B, 0x8C, 0xA0, 0xA1, 0xA2, 0xA8, 0xAD, 0xB0, 0xB1, 0xB3, 0xBB, 0xBE, 0x26 -> 1
    - 0x21 -> 7; 0x22 -> 10; 0x23 -> 6; 0x24 -> 4; 0x25 -> 4; 0x27 -> 5
    - all others -> 0
  - K > 0 -> ARGS with the index at 0. K = 0 -> stay in IDLE.
- ARGS, command byte:
  - Pulse o_ARG_VALID with o_ARG_IDX = current index, then increment the index.
  - After the K-th argument, return to IDLE.
  - 0x15: arg0 = column start, arg1 = column end. 0x75: arg0 = row start, arg1 = row end.
  - After the end argument, the pointer column/row is set to the new start.
  - Values >= NUM_COL/NUM_ROW saturate to NUM_COL-1/NUM_ROW-1.
- Data byte (DC = 1) in either state:
  - Pulse o_PIX_VALID with o_PIX_DATA = byte at the current pointer.
  - Column advance: col == col_end -> col = col_start and row advances; otherwise col + 1.
  - Row advance: row == row_end -> row = row_start; otherwise row + 1.
  - A data byte in ARGS does not consume an argument.
- Inverted window (start > end): comparisons use equality only. The pointer counts up and wraps from max to 0 until it reaches end.
- Simultaneous CS rise and the N-th edge in the same cycle: the byte completes (counter at N) and o_FRAME_ERR stays clear.

Test Plan:
- Byte timing: CS = 0, DC = 0, shift 0xAF at SCK 2.5 MHz -> o_BYTE = 0xAF, o_BYTE_DC = 0, one o_BYTE_VALID 4 clocks after the 8th SCK rise; parser stays IDLE (K = 0).
- Window set: send 0x15, 0x10, 0x12, 0x75, 0x05, 0x06 -> four o_ARG_VALID pulses with idx 0, 1, 0, 1; pointer = (16, 5).
- Pixel wrap: after the window above, send 7 data bytes 0x00..0x06 -> (col,row) = (16,5), (17,5), (18,5), (16,6), (17,6), (18,6), (16,5).
- Abort: CS = 0, 5 SCK rises, CS = 1 -> no o_BYTE_VALID, o_FRAME_ERR = 1. The next full byte 0x5A is received intact.
- Long command: 0x22 plus 10 args -> o_ARG_IDX 0..9, then 0xAE decodes as a new opcode.
- Reset mid-byte: assert i_RST after 3 bits -> all outputs 0 immediately (asynchronous). After release, a full 0x3C is received correctly. Pulsing i_RES low restores the window to 0..95 / 0..63.

Source files
------------

// File: rtl/ssd1331_spi_responder.sv
// Receive-side SSD1331 model: oversamples the PMOD SPI pins, deserialises bytes,
// decodes command/argument framing and tracks the GDDRAM write pointer.
//
// state  | meaning
// IDLE   | next command byte is an opcode
// ARGS   | command bytes are arguments of o_CMD until the count runs out
module ssd1331_spi_responder #(
    parameter int N       = 8,
    parameter int NUM_COL = 96,
    parameter int NUM_ROW = 64,
    localparam int CW     = $clog2(NUM_COL),
    localparam int RW     = $clog2(NUM_ROW)
) (
    input  logic          i_CLK,
    input  logic          i_RST,
    input  logic          i_CS,
    input  logic          i_MOSI,
    input  logic          i_SCK,
    input  logic          i_DC,
    input  logic          i_RES,
    output logic [N-1:0]  o_BYTE,
    output logic          o_BYTE_DC,
    output logic          o_BYTE_VALID,
    output logic [7:0]    o_CMD,
    output logic [3:0]    o_ARG_IDX,
    output logic          o_ARG_VALID,
    output logic [7:0]    o_PIX_DATA,
    output logic [CW-1:0] o_PIX_COL,
    output logic [RW-1:0] o_PIX_ROW,
    output logic          o_PIX_VALID,
    output logic          o_FRAME_ERR
);

    localparam int BCW = $clog2(N);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ARGS = 1'b1;

    logic cs_s1, cs_s2;
    logic mosi_s1, mosi_s2;
    logic sck_s1, sck_s2, sck_s3;
    logic dc_s1, dc_s2;
    logic res_s1, res_s2;

    logic [BCW-1:0] bit_cnt;
    logic [N-1:0]   shift_reg;
    logic           byte_done;
    logic           dc_cap;
    logic           sck_rise;
    logic           last_bit;
    logic           shift_take;

    logic [0:0]    state;
    logic [3:0]    args_left;
    logic [3:0]    arg_num;
    logic [CW-1:0] col_start, col_end, col_ptr;
    logic [RW-1:0] row_start, row_end, row_ptr;
    logic [CW-1:0] col_inc, next_col, sat_col;
    logic [RW-1:0] row_inc, next_row, sat_row;

    // CS and RES flops reset to their inactive level so reset release cannot fake activity.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_s3  <= 1'b0;
            dc_s1   <= 1'b0;
            dc_s2   <= 1'b0;
            res_s1  <= 1'b1;
            res_s2  <= 1'b1;
        end else begin
            cs_s1   <= i_CS;
            cs_s2   <= cs_s1;
            mosi_s1 <= i_MOSI;
            mosi_s2 <= mosi_s1;
            sck_s1  <= i_SCK;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            dc_s1   <= i_DC;
            dc_s2   <= dc_s1;
            res_s1  <= i_RES;
            res_s2  <= res_s1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_s3;
    assign last_bit = (bit_cnt == BCW'(N - 1));
    // A final edge arriving together with CS release still completes the byte.
    assign shift_take = sck_rise && (!cs_s2 || last_bit);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            bit_cnt     <= '0;
            shift_reg   <= '0;
            byte_done   <= 1'b0;
            dc_cap      <= 1'b0;
            o_FRAME_ERR <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (!res_s2) begin
                bit_cnt <= '0;
            end else if (shift_take) begin
                shift_reg <= {shift_reg[N-2:0], mosi_s2};
                if (last_bit) begin
                    bit_cnt   <= '0;
                    byte_done <= 1'b1;
                    dc_cap    <= dc_s2;
                end else begin
                    bit_cnt <= bit_cnt + BCW'(1);
                end
            end else if (cs_s2) begin
                bit_cnt <= '0;
                if (bit_cnt != '0) o_FRAME_ERR <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_BYTE       <= '0;
            o_BYTE_DC    <= 1'b0;
            o_BYTE_VALID <= 1'b0;
        end else begin
            o_BYTE_VALID <= byte_done;
            if (byte_done) begin
                o_BYTE    <= shift_reg;
                o_BYTE_DC <= dc_cap;
            end
        end
    end

    function automatic logic [3:0] arg_count(input logic [7:0] op);
        case (op)
            8'h15, 8'h75: arg_count = 4'd2;
            8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B, 8'h8C,
            8'hA0, 8'hA1, 8'hA2, 8'hA8, 8'hAD, 8'hB0, 8'hB1,
            8'hB3, 8'hBB, 8'hBE, 8'h26: arg_count = 4'd1;
            8'h21: arg_count = 4'd7;
            8'h22: arg_count = 4'd10;
            8'h23: arg_count = 4'd6;
            8'h24, 8'h25: arg_count = 4'd4;
            8'h27: arg_count = 4'd5;
            default: arg_count = 4'd0;
        endcase
    endfunction

    // Equality-only wrap tests keep an inverted window walking up through max to 0.
    always_comb begin
        col_inc  = (col_ptr == CW'(NUM_COL - 1)) ? '0 : col_ptr + CW'(1);
        row_inc  = (row_ptr == RW'(NUM_ROW - 1)) ? '0 : row_ptr + RW'(1);
        next_col = col_inc;
        next_row = row_ptr;
        if (col_ptr == col_end) begin
            next_col = col_start;
            next_row = (row_ptr == row_end) ? row_start : row_inc;
        end
        sat_col = (o_BYTE >= N'(NUM_COL)) ? CW'(NUM_COL - 1) : CW'(o_BYTE);
        sat_row = (o_BYTE >= N'(NUM_ROW)) ? RW'(NUM_ROW - 1) : RW'(o_BYTE);
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state       <= S_IDLE;
            args_left   <= '0;
            arg_num     <= '0;
            o_CMD       <= '0;
            o_ARG_IDX   <= '0;
            o_ARG_VALID <= 1'b0;
            o_PIX_DATA  <= '0;
            o_PIX_COL   <= '0;
            o_PIX_ROW   <= '0;
            o_PIX_VALID <= 1'b0;
            col_start   <= '0;
            col_end     <= CW'(NUM_COL - 1);
            row_start   <= '0;
            row_end     <= RW'(NUM_ROW - 1);
            col_ptr     <= '0;
            row_ptr     <= '0;
        end else begin
            o_ARG_VALID <= 1'b0;
            o_PIX_VALID <= 1'b0;
            if (!res_s2) begin
                state     <= S_IDLE;
                args_left <= '0;
                arg_num   <= '0;
                col_start <= '0;
                col_end   <= CW'(NUM_COL - 1);
                row_start <= '0;
                row_end   <= RW'(NUM_ROW - 1);
                col_ptr   <= '0;
                row_ptr   <= '0;
            end else if (o_BYTE_VALID) begin
                if (o_BYTE_DC) begin
                    o_PIX_VALID <= 1'b1;
                    o_PIX_DATA  <= 8'(o_BYTE);
                    o_PIX_COL   <= col_ptr;
                    o_PIX_ROW   <= row_ptr;
                    col_ptr     <= next_col;
                    row_ptr     <= next_row;
                end else if (state == S_IDLE) begin
                    o_CMD     <= 8'(o_BYTE);
                    args_left <= arg_count(8'(o_BYTE));
                    arg_num   <= '0;
                    if (arg_count(8'(o_BYTE)) != 4'd0) state <= S_ARGS;
                end else begin
                    o_ARG_VALID <= 1'b1;
                    o_ARG_IDX   <= arg_num;
                    arg_num     <= arg_num + 4'd1;
                    args_left   <= args_left - 4'd1;
                    if (args_left == 4'd1) state <= S_IDLE;
                    if (o_CMD == 8'h15) begin
                        if (arg_num == 4'd0) begin
                            col_start <= sat_col;
                        end else if (arg_num == 4'd1) begin
                            col_end <= sat_col;
                            col_ptr <= col_start;
                        end
                    end else if (o_CMD == 8'h75) begin
                        if (arg_num == 4'd0) begin
                            row_start <= sat_row;
                        end else if (arg_num == 4'd1) begin
                            row_end <= sat_row;
                            row_ptr <= row_start;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ssd1331_spi_responder.sv
// Directed bench for ssd1331_spi_responder: SPI byte timing, command framing,
// window/pointer walk, abort handling and both reset paths.
module tb_ssd1331_spi_responder;

    logic       clk = 1'b0;
    logic       rst, cs, mosi, sck, dc, res;
    logic [7:0] o_byte;
    logic       o_byte_dc, o_byte_valid;
    logic [7:0] o_cmd;
    logic [3:0] o_arg_idx;
    logic       o_arg_valid;
    logic [7:0] o_pix_data;
    logic [6:0] o_pix_col;
    logic [5:0] o_pix_row;
    logic       o_pix_valid, o_frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int half  = 4;
    int byte_cnt = 0;
    logic [3:0] arg_q[$];
    logic [6:0] col_q[$];
    logic [5:0] row_q[$];
    logic [7:0] pdat_q[$];

    ssd1331_spi_responder dut (
        .i_CLK(clk), .i_RST(rst), .i_CS(cs), .i_MOSI(mosi), .i_SCK(sck),
        .i_DC(dc), .i_RES(res),
        .o_BYTE(o_byte), .o_BYTE_DC(o_byte_dc), .o_BYTE_VALID(o_byte_valid),
        .o_CMD(o_cmd), .o_ARG_IDX(o_arg_idx), .o_ARG_VALID(o_arg_valid),
        .o_PIX_DATA(o_pix_data), .o_PIX_COL(o_pix_col), .o_PIX_ROW(o_pix_row),
        .o_PIX_VALID(o_pix_valid), .o_FRAME_ERR(o_frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_byte_valid) byte_cnt++;
        if (o_arg_valid) arg_q.push_back(o_arg_idx);
        if (o_pix_valid) begin
            col_q.push_back(o_pix_col);
            row_q.push_back(o_pix_row);
            pdat_q.push_back(o_pix_data);
        end
    end

    task automatic clear_logs();
        arg_q.delete();
        col_q.delete();
        row_q.delete();
        pdat_q.delete();
    endtask

    task automatic bit_rise(input logic v);
        mosi = v;
        repeat (half) @(posedge clk);
        #2 sck = 1'b1;
    endtask

    task automatic bit_fall();
        repeat (half) @(posedge clk);
        #2 sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, input logic d);
        dc = d;
        for (int i = 7; i >= 0; i--) begin
            bit_rise(b[i]);
            bit_fall();
        end
        repeat (6) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (o_byte !== 8'h00) begin n_bad++; $display("FAIL reset_byte: got %h want 00", o_byte); end
        n_cmp++; if (o_byte_valid !== 1'b0) begin n_bad++; $display("FAIL reset_byte_valid: got %b want 0", o_byte_valid); end
        n_cmp++; if (o_cmd !== 8'h00) begin n_bad++; $display("FAIL reset_cmd: got %h want 00", o_cmd); end
        n_cmp++; if ({o_pix_col, o_pix_row, o_pix_data} !== 21'd0) begin n_bad++; $display("FAIL reset_pix: got %h/%h/%h want 0", o_pix_col, o_pix_row, o_pix_data); end
        n_cmp++; if (o_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", o_frame_err); end
    endtask

    task automatic test_byte_timing();
        logic [7:0] b;
        int start_cnt;
        b = 8'hAF;
        half = 20;
        start_cnt = byte_cnt;
        cs = 1'b0;
        dc = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            bit_rise(b[i]);
            if (i == 0) begin
                repeat (3) @(posedge clk);
                #1;
                n_cmp++; if (o_byte_valid !== 1'b0) begin n_bad++; $display("FAIL timing_early: got %b want 0 at edge 3", o_byte_valid); end
                @(posedge clk); #1;
                n_cmp++; if (o_byte_valid !== 1'b1) begin n_bad++; $display("FAIL timing_edge4: got %b want 1", o_byte_valid); end
                n_cmp++; if (o_byte !== 8'hAF) begin n_bad++; $display("FAIL timing_byte: got %h want af", o_byte); end
                n_cmp++; if (o_byte_dc !== 1'b0) begin n_bad++; $display("FAIL timing_dc: got %b want 0", o_byte_dc); end
                @(posedge clk); #1;
                n_cmp++; if (o_byte_valid !== 1'b0) begin n_bad++; $display("FAIL timing_width: got %b want 0", o_byte_valid); end
            end
            bit_fall();
        end
        repeat (6) @(posedge clk);
        n_cmp++; if (byte_cnt - start_cnt !== 1) begin n_bad++; $display("FAIL timing_count: got %0d want 1", byte_cnt - start_cnt); end
        n_cmp++; if (o_cmd !== 8'hAF) begin n_bad++; $display("FAIL timing_cmd: got %h want af", o_cmd); end
        half = 4;
    endtask

    task automatic test_window();
        logic [3:0] exp_idx[4] = '{4'd0, 4'd1, 4'd0, 4'd1};
        logic [7:0] seq[6] = '{8'h15, 8'h10, 8'h12, 8'h75, 8'h05, 8'h06};
        clear_logs();
        foreach (seq[i]) spi_byte(seq[i], 1'b0);
        n_cmp++; if (arg_q.size() !== 4) begin n_bad++; $display("FAIL window_arg_count: got %0d want 4", arg_q.size()); end
        for (int i = 0; i < 4 && i < arg_q.size(); i++) begin
            n_cmp++; if (arg_q[i] !== exp_idx[i]) begin n_bad++; $display("FAIL window_arg_idx[%0d]: got %0d want %0d", i, arg_q[i], exp_idx[i]); end
        end
        n_cmp++; if (o_cmd !== 8'h75) begin n_bad++; $display("FAIL window_cmd: got %h want 75", o_cmd); end
    endtask

    task automatic test_pixel_wrap();
        logic [6:0] ec[7] = '{7'd16, 7'd17, 7'd18, 7'd16, 7'd17, 7'd18, 7'd16};
        logic [5:0] er[7] = '{6'd5, 6'd5, 6'd5, 6'd6, 6'd6, 6'd6, 6'd5};
        clear_logs();
        for (int i = 0; i < 7; i++) spi_byte(8'(i), 1'b1);
        n_cmp++; if (col_q.size() !== 7) begin n_bad++; $display("FAIL wrap_count: got %0d want 7", col_q.size()); end
        for (int i = 0; i < 7 && i < col_q.size(); i++) begin
            n_cmp++;
            if (col_q[i] !== ec[i] || row_q[i] !== er[i] || pdat_q[i] !== 8'(i)) begin
                n_bad++;
                $display("FAIL wrap_pix[%0d]: got (%0d,%0d) d=%h want (%0d,%0d) d=%h", i, col_q[i], row_q[i], pdat_q[i], ec[i], er[i], 8'(i));
            end
        end
        n_cmp++; if (arg_q.size() !== 0) begin n_bad++; $display("FAIL wrap_no_args: got %0d want 0", arg_q.size()); end
    endtask

    task automatic test_abort();
        int start_cnt;
        start_cnt = byte_cnt;
        cs = 1'b0;
        dc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_rise(1'b1);
            bit_fall();
        end
        repeat (4) @(posedge clk);
        #2 cs = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++; if (byte_cnt !== start_cnt) begin n_bad++; $display("FAIL abort_no_byte: got %0d want %0d", byte_cnt, start_cnt); end
        n_cmp++; if (o_frame_err !== 1'b1) begin n_bad++; $display("FAIL abort_frame_err: got %b want 1", o_frame_err); end
        cs = 1'b0;
        spi_byte(8'h5A, 1'b0);
        n_cmp++; if (o_byte !== 8'h5A || byte_cnt !== start_cnt + 1) begin n_bad++; $display("FAIL abort_next_byte: got %h cnt %0d want 5a cnt %0d", o_byte, byte_cnt - start_cnt, 1); end
    endtask

    task automatic test_long_cmd();
        clear_logs();
        spi_byte(8'h22, 1'b0);
        n_cmp++; if (o_cmd !== 8'h22) begin n_bad++; $display("FAIL long_cmd_op: got %h want 22", o_cmd); end
        for (int i = 0; i < 5; i++) spi_byte(8'(8'h40 + i), 1'b0);
        spi_byte(8'h77, 1'b1);
        for (int i = 5; i < 10; i++) spi_byte(8'(8'h40 + i), 1'b0);
        n_cmp++; if (arg_q.size() !== 10) begin n_bad++; $display("FAIL long_arg_count: got %0d want 10", arg_q.size()); end
        for (int i = 0; i < 10 && i < arg_q.size(); i++) begin
            n_cmp++; if (arg_q[i] !== 4'(i)) begin n_bad++; $display("FAIL long_arg_idx[%0d]: got %0d want %0d", i, arg_q[i], i); end
        end
        n_cmp++;
        if (pdat_q.size() !== 1 || col_q[0] !== 7'd17 || row_q[0] !== 6'd5 || pdat_q[0] !== 8'h77) begin
            n_bad++; $display("FAIL long_mid_pixel: got n=%0d (%0d,%0d) d=%h want n=1 (17,5) d=77", pdat_q.size(), col_q[0], row_q[0], pdat_q[0]);
        end
        spi_byte(8'hAE, 1'b0);
        n_cmp++; if (o_cmd !== 8'hAE) begin n_bad++; $display("FAIL long_next_op: got %h want ae", o_cmd); end
        n_cmp++; if (arg_q.size() !== 10) begin n_bad++; $display("FAIL long_no_extra_arg: got %0d want 10", arg_q.size()); end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] b;
        b = 8'hC3;
        cs = 1'b0;
        dc = 1'b0;
        for (int i = 7; i >= 5; i--) begin
            bit_rise(b[i]);
            bit_fall();
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (o_byte !== 8'h00) begin n_bad++; $display("FAIL rst_async_byte: got %h want 00", o_byte); end
        n_cmp++; if (o_cmd !== 8'h00 || o_arg_idx !== 4'd0) begin n_bad++; $display("FAIL rst_async_cmd: got %h/%0d want 00/0", o_cmd, o_arg_idx); end
        n_cmp++; if (o_pix_data !== 8'h00 || o_pix_col !== 7'd0 || o_pix_row !== 6'd0) begin n_bad++; $display("FAIL rst_async_pix: got %h (%0d,%0d) want 00 (0,0)", o_pix_data, o_pix_col, o_pix_row); end
        n_cmp++; if (o_frame_err !== 1'b0) begin n_bad++; $display("FAIL rst_async_frame_err: got %b want 0", o_frame_err); end
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        spi_byte(8'h3C, 1'b0);
        n_cmp++; if (o_byte !== 8'h3C) begin n_bad++; $display("FAIL rst_next_byte: got %h want 3c", o_byte); end
    endtask

    task automatic test_soft_reset();
        cs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_rise(1'b0);
            bit_fall();
        end
        repeat (2) @(posedge clk);
        #2 cs = 1'b1;
        repeat (6) @(posedge clk);
        #2 cs = 1'b0;
        spi_byte(8'h15, 1'b0);
        spi_byte(8'h20, 1'b0);
        spi_byte(8'h30, 1'b0);
        res = 1'b0;
        repeat (10) @(posedge clk);
        #2 res = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (o_frame_err !== 1'b1) begin n_bad++; $display("FAIL res_keeps_frame_err: got %b want 1", o_frame_err); end
        clear_logs();
        for (int i = 0; i < 97; i++) spi_byte(8'(i), 1'b1);
        n_cmp++; if (col_q.size() !== 97) begin n_bad++; $display("FAIL res_pix_count: got %0d want 97", col_q.size()); end
        if (col_q.size() == 97) begin
            n_cmp++; if (col_q[0] !== 7'd0 || row_q[0] !== 6'd0) begin n_bad++; $display("FAIL res_first_pix: got (%0d,%0d) want (0,0)", col_q[0], row_q[0]); end
            n_cmp++; if (col_q[95] !== 7'd95 || row_q[95] !== 6'd0) begin n_bad++; $display("FAIL res_col_end: got (%0d,%0d) want (95,0)", col_q[95], row_q[95]); end
            n_cmp++; if (col_q[96] !== 7'd0 || row_q[96] !== 6'd1) begin n_bad++; $display("FAIL res_col_wrap: got (%0d,%0d) want (0,1)", col_q[96], row_q[96]); end
        end
    endtask

    task automatic test_saturation();
        logic [6:0] ec[3] = '{7'd95, 7'd95, 7'd95};
        logic [5:0] er[3] = '{6'd62, 6'd63, 6'd62};
        spi_byte(8'h15, 1'b0);
        spi_byte(8'h5F, 1'b0);
        spi_byte(8'hFF, 1'b0);
        spi_byte(8'h75, 1'b0);
        spi_byte(8'h3E, 1'b0);
        spi_byte(8'hFF, 1'b0);
        clear_logs();
        for (int i = 0; i < 3; i++) spi_byte(8'hE0, 1'b1);
        n_cmp++; if (col_q.size() !== 3) begin n_bad++; $display("FAIL sat_count: got %0d want 3", col_q.size()); end
        for (int i = 0; i < 3 && i < col_q.size(); i++) begin
            n_cmp++; if (col_q[i] !== ec[i] || row_q[i] !== er[i]) begin n_bad++; $display("FAIL sat_pix[%0d]: got (%0d,%0d) want (%0d,%0d)", i, col_q[i], row_q[i], ec[i], er[i]); end
        end
    endtask

    initial begin
        rst  = 1'b1;
        cs   = 1'b1;
        mosi = 1'b0;
        sck  = 1'b0;
        dc   = 1'b0;
        res  = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        test_byte_timing();
        test_window();
        test_pixel_wrap();
        test_abort();
        test_long_cmd();
        test_reset_mid_byte();
        test_soft_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
